alu_uart_host: RTL and testbench

//  Host-side command initiator for the UART ALU: the opposite end of the link.
//  - Takes one operation request and sends operando1, operando2 and opcode as three bytes.
//  - Sends them through a byte-level tx_uart, then waits for the one-byte result from an rx_uart.
//  - Drives the DUT in board loopback and system benches.
//  - Reports result or timeout to a local controller.

---
 rtl/alu_uart_host.sv | 155 +++++++++++++++
 tb/tb_alu_uart_host.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_host.sv
// Host-side initiator for the UART ALU link: sends op1, op2 and opcode as three
// bytes through a byte-level tx_uart, then waits for the one-byte result.
module alu_uart_host #(
    parameter int DATA_BITS      = 8,
    parameter int OPCODE_BITS    = 6,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [DATA_BITS-1:0]   i_operando1,
    input  logic [DATA_BITS-1:0]   i_operando2,
    input  logic [OPCODE_BITS-1:0] i_opcode,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [DATA_BITS-1:0]   o_result,
    output logic                   o_timeout,
    output logic [DATA_BITS-1:0]   o_tx_data,
    output logic                   o_tx_data_ready,
    input  logic                   i_available_tx,
    input  logic [DATA_BITS-1:0]   i_rx_data,
    input  logic                   i_rx_data_ready
);
    localparam int                  CNT_BITS = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_OP1, WAIT_OP1, SEND_OP2, WAIT_OP2, SEND_OPC, WAIT_OPC, WAIT_RES
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   op1_q, op1_d;
    logic [DATA_BITS-1:0]   op2_q, op2_d;
    logic [OPCODE_BITS-1:0] opc_q, opc_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic [DATA_BITS-1:0]   result_q, result_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   seen_busy_q, seen_busy_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   tx_strobe;
    logic                   tx_released;
    logic [DATA_BITS-1:0]   opc_byte;

    assign opc_byte    = DATA_BITS'(opc_q);
    // A byte is only finished once the transmitter was seen busy and is idle again.
    assign tx_released = seen_busy_q && i_available_tx;

    always_comb begin
        // NOTE: every signal gets its default first so no path can infer a latch.
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        opc_d       = opc_q;
        tx_data_d   = tx_data_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        tx_strobe   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    op1_d     = i_operando1;
                    op2_d     = i_operando2;
                    opc_d     = i_opcode;
                    tx_data_d = i_operando1;
                    busy_d    = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = SEND_OP1;
                end
            end
            SEND_OP1, SEND_OP2, SEND_OPC: begin
                if (i_available_tx) begin
                    tx_strobe   = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = (state_q == SEND_OP1) ? WAIT_OP1 :
                                  (state_q == SEND_OP2) ? WAIT_OP2 : WAIT_OPC;
                end
            end
            WAIT_OP1, WAIT_OP2, WAIT_OPC: begin
                if (!i_available_tx) begin
                    seen_busy_d = 1'b1;
                end
                if (tx_released) begin
                    if (state_q == WAIT_OP1) begin
                        tx_data_d = op2_q;
                        state_d   = SEND_OP2;
                    end else if (state_q == WAIT_OP2) begin
                        tx_data_d = opc_byte;
                        state_d   = SEND_OPC;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RES;
                    end
                end
            end
            WAIT_RES: begin
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
                // A result arriving on the expiry cycle takes priority over the timeout.
                if (i_rx_data_ready) begin
                    result_d = i_rx_data;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            opc_q       <= '0;
            tx_data_q   <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opc_q       <= opc_d;
            tx_data_q   <= tx_data_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_result        = result_q;
    assign o_timeout       = timeout_q;
    assign o_tx_data       = tx_data_q;
    assign o_tx_data_ready = tx_strobe;
endmodule

// File: tb/tb_alu_uart_host.sv
// Scoreboard bench for alu_uart_host: a tx_uart model consumes strobes and checks
// bytes against a queue; a done monitor checks results against a second queue.
module tb_alu_uart_host;
    localparam int TO = 100;

    typedef struct {
        logic [7:0] result;
        logic       timeout;
        int         edge_no;
    } res_t;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_operando1 = '0;
    logic [7:0] i_operando2 = '0;
    logic [5:0] i_opcode = '0;
    logic       o_busy, o_done, o_timeout, o_tx_data_ready;
    logic [7:0] o_result, o_tx_data;
    logic       i_available_tx;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_data_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] exp_tx[$];
    res_t       exp_res[$];

    int         pre_hold = 0;
    int         tx_busy_len = 3;
    int         low_cnt = 0;
    int         txn_strobes = 0;
    int         strobe_total = 0;
    int         done_total = 0;
    int         first_strobe_edge = -1;
    int         last_strobe_edge = -100;
    logic [7:0] last_strobe_data = '0;
    logic [7:0] last_good = '0;

    alu_uart_host #(
        .DATA_BITS(8), .OPCODE_BITS(6), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_operando1(i_operando1), .i_operando2(i_operando2), .i_opcode(i_opcode),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_timeout(o_timeout),
        .o_tx_data(o_tx_data), .o_tx_data_ready(o_tx_data_ready),
        .i_available_tx(i_available_tx), .i_rx_data(i_rx_data),
        .i_rx_data_ready(i_rx_data_ready)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) cyc <= cyc + 1;

    // tx_uart model and done monitor: sample at negedge, drive 1 time unit after posedge.
    initial begin : tx_model
        res_t       r;
        logic [7:0] e;
        i_available_tx = 1'b1;
        forever begin
            @(negedge i_clock);
            if (i_reset && i_start && !o_busy) begin
                low_cnt     = pre_hold;
                txn_strobes = 0;
            end
            if (o_tx_data_ready) begin
                checks++;
                if (!i_available_tx) begin
                    errors++;
                    $display("FAIL strobe_when_busy: available=%b, required 1", i_available_tx);
                end
                checks++;
                if (cyc + 1 - last_strobe_edge < 2) begin
                    errors++;
                    $display("FAIL strobe_spacing: gap=%0d, required >=2", cyc + 1 - last_strobe_edge);
                end
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: data=%h, required no strobe", o_tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    if (o_tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %h, required %h", o_tx_data, e);
                    end
                end
                if (txn_strobes == 0) first_strobe_edge = cyc + 1;
                last_strobe_edge = cyc + 1;
                last_strobe_data = o_tx_data;
                txn_strobes++;
                strobe_total++;
                low_cnt = tx_busy_len;
            end else if (i_reset && o_busy && txn_strobes > 0 && !i_available_tx) begin
                checks++;
                if (o_tx_data !== last_strobe_data) begin
                    errors++;
                    $display("FAIL tx_data_stable: got %h, required %h", o_tx_data, last_strobe_data);
                end
            end
            if (o_done) begin
                done_total++;
                checks++;
                if (exp_res.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done with result %h at edge %0d, required no done", o_result, cyc);
                end else begin
                    r = exp_res.pop_front();
                    if (o_result !== r.result) begin
                        errors++;
                        $display("FAIL done_result: got %h, required %h", o_result, r.result);
                    end
                    checks++;
                    if (o_timeout !== r.timeout) begin
                        errors++;
                        $display("FAIL done_timeout: got %b, required %b", o_timeout, r.timeout);
                    end
                    checks++;
                    if (cyc != r.edge_no) begin
                        errors++;
                        $display("FAIL done_edge: got %0d, required %0d", cyc, r.edge_no);
                    end
                    checks++;
                    if (o_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done_busy: got %b, required 0", o_busy);
                    end
                end
            end
            @(posedge i_clock);
            #1;
            if (low_cnt > 0) begin
                i_available_tx = 1'b0;
                low_cnt--;
            end else begin
                i_available_tx = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, required earlier completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic wait_strobes(input int n);
        int k = 0;
        while (txn_strobes < n && k < 2000) begin
            @(posedge i_clock);
            #1;
            k++;
        end
        checks++;
        if (txn_strobes < n) begin
            errors++;
            $display("FAIL strobe_wait: got %0d strobes, required %0d", txn_strobes, n);
        end
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                            output int acc);
        i_operando1 = a;
        i_operando2 = b;
        i_opcode    = op;
        i_start     = 1'b1;
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        exp_tx.push_back({2'b00, op});
        tick(1);
        i_start = 1'b0;
        acc     = cyc;
    endtask

    task automatic rx_pulse(input logic [7:0] data);
        i_rx_data       = data;
        i_rx_data_ready = 1'b1;
        tick(1);
        i_rx_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        int acc, base;
        tick(3);
        checks++;
        if ({o_busy, o_done, o_timeout, o_tx_data_ready, o_result, o_tx_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%h/%h, required all 0",
                     o_busy, o_done, o_timeout, o_tx_data_ready, o_result, o_tx_data);
        end
        i_reset = 1'b1;
        tick(2);
        do_start(8'hC1, 8'hC2, 6'h11, acc);
        wait_strobes(2);
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_timeout, o_tx_data_ready, o_result, o_tx_data} !== '0) begin
            errors++;
            $display("FAIL reset_midtxn: got %b/%b/%b/%b/%h/%h, required all 0",
                     o_busy, o_done, o_timeout, o_tx_data_ready, o_result, o_tx_data);
        end
        exp_tx.delete();
        base = strobe_total;
        tick(2);
        i_reset = 1'b1;
        tick(10);
        checks++;
        if (strobe_total != base) begin
            errors++;
            $display("FAIL reset_no_strobe: got %0d strobes, required 0", strobe_total - base);
        end
        checks++;
        if (o_busy !== 1'b0 || done_total != 0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b dones=%0d, required 0 and 0", o_busy, done_total);
        end
    endtask

    task automatic test_happy();
        int acc, e0, base;
        base = done_total;
        do_start(8'h05, 8'h03, 6'h20, acc);
        wait_strobes(3);
        checks++;
        if (first_strobe_edge != acc + 1) begin
            errors++;
            $display("FAIL first_strobe_latency: edge %0d, required %0d", first_strobe_edge, acc + 1);
        end
        e0 = last_strobe_edge + tx_busy_len + 1;
        wait_cyc(e0 + 4);
        exp_res.push_back('{result: 8'h08, timeout: 1'b0, edge_no: e0 + 5});
        rx_pulse(8'h08);
        wait_cyc(e0 + 7);
        checks++;
        if (done_total != base + 1) begin
            errors++;
            $display("FAIL happy_done_count: got %0d, required %0d", done_total - base, 1);
        end
        rx_pulse(8'h77);
        tick(5);
        checks++;
        if (o_result !== 8'h08 || done_total != base + 1) begin
            errors++;
            $display("FAIL late_rx_discard: result=%h dones=%0d, required 08 and 1", o_result, done_total - base);
        end
        last_good = 8'h08;
    endtask

    task automatic test_backpressure();
        int acc, e0, base, sbase;
        base        = done_total;
        sbase       = strobe_total;
        pre_hold    = 50;
        tx_busy_len = 50;
        do_start(8'hA5, 8'h5A, 6'h3F, acc);
        wait_strobes(3);
        checks++;
        if (first_strobe_edge != acc + 51) begin
            errors++;
            $display("FAIL bp_first_strobe: edge %0d, required %0d", first_strobe_edge, acc + 51);
        end
        e0 = last_strobe_edge + tx_busy_len + 1;
        wait_cyc(e0 + 1);
        exp_res.push_back('{result: 8'h42, timeout: 1'b0, edge_no: e0 + 2});
        rx_pulse(8'h42);
        wait_cyc(e0 + 5);
        checks++;
        if (strobe_total - sbase != 3 || done_total != base + 1) begin
            errors++;
            $display("FAIL bp_totals: strobes=%0d dones=%0d, required 3 and 1", strobe_total - sbase, done_total - base);
        end
        pre_hold    = 0;
        tx_busy_len = 3;
        last_good   = 8'h42;
    endtask

    task automatic test_timeout();
        int acc, e0, base;
        base = done_total;
        do_start(8'h10, 8'h20, 6'h05, acc);
        wait_strobes(3);
        e0 = last_strobe_edge + tx_busy_len + 1;
        exp_res.push_back('{result: last_good, timeout: 1'b1, edge_no: e0 + TO});
        wait_cyc(e0 + TO - 1);
        checks++;
        if (o_done !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: done=%b timeout=%b, required 0 and 0", o_done, o_timeout);
        end
        wait_cyc(e0 + TO + 2);
        checks++;
        if (done_total != base + 1 || o_timeout !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: dones=%0d timeout=%b busy=%b, required 1, 1, 0",
                     done_total - base, o_timeout, o_busy);
        end
    endtask

    task automatic test_race();
        int acc, s1, e0, d, base;
        base = done_total;
        do_start(8'h01, 8'h02, 6'h03, acc);
        checks++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_clears_timeout: timeout=%b busy=%b, required 0 and 1", o_timeout, o_busy);
        end
        wait_strobes(1);
        s1 = first_strobe_edge;
        wait_cyc(s1 + 4);
        rx_pulse(8'hEE);
        wait_strobes(3);
        e0 = last_strobe_edge + tx_busy_len + 1;
        d  = e0 + TO;
        exp_res.push_back('{result: 8'h5C, timeout: 1'b0, edge_no: d});
        wait_cyc(d - 1);
        rx_pulse(8'h5C);
        wait_cyc(d + 2);
        checks++;
        if (done_total != base + 1 || o_result !== 8'h5C || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL race: dones=%0d result=%h timeout=%b, required 1, 5c, 0",
                     done_total - base, o_result, o_timeout);
        end
        last_good = 8'h5C;
    endtask

    task automatic test_back_to_back();
        int acc, s1, e0, d, base;
        base = done_total;
        do_start(8'h11, 8'h22, 6'h33, acc);
        wait_strobes(1);
        s1 = first_strobe_edge;
        wait_cyc(s1 + 1);
        i_operando1 = 8'h99;
        i_operando2 = 8'h99;
        i_opcode    = 6'h19;
        i_start     = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_strobes(3);
        e0 = last_strobe_edge + tx_busy_len + 1;
        d  = e0 + TO;
        exp_res.push_back('{result: last_good, timeout: 1'b1, edge_no: d});
        wait_cyc(d);
        checks++;
        if (o_done !== 1'b1 || o_timeout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_cycle: done=%b timeout=%b, required 1 and 1", o_done, o_timeout);
        end
        do_start(8'h44, 8'h55, 6'h26, acc);
        checks++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b1 || acc != d + 1) begin
            errors++;
            $display("FAIL b2b_accept: timeout=%b busy=%b edge=%0d, required 0, 1, %0d",
                     o_timeout, o_busy, acc, d + 1);
        end
        wait_strobes(3);
        checks++;
        if (first_strobe_edge != d + 2) begin
            errors++;
            $display("FAIL b2b_first_strobe: edge %0d, required %0d", first_strobe_edge, d + 2);
        end
        e0 = last_strobe_edge + tx_busy_len + 1;
        wait_cyc(e0 + 1);
        exp_res.push_back('{result: 8'h99, timeout: 1'b0, edge_no: e0 + 2});
        rx_pulse(8'h99);
        wait_cyc(e0 + 5);
        checks++;
        if (done_total != base + 2 || exp_res.size() != 0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL b2b_totals: dones=%0d res_left=%0d tx_left=%0d, required 2, 0, 0",
                     done_total - base, exp_res.size(), exp_tx.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_happy();
        test_backpressure();
        test_timeout();
        test_race();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
